// File: rtl/stream_pkt_gen_pkg.sv
// Shared types and constants for the stream packet generator.
package stream_pkt_gen_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} pkt_state_e;
  localparam int PKT_CNT_W = 16;
endpackage

// File: rtl/axi_stream_inf.sv
// AXI-Stream bundle; aclk is tied to the system clock by the parent.
interface axi_stream_inf #(parameter int DSIZE = 8) (input logic aclk);
  localparam int KSIZE = (DSIZE + 7) / 8;
  logic             axis_tvalid;
  logic             axis_tready;
  logic [DSIZE-1:0] axis_tdata;
  logic             axis_tlast;
  logic [KSIZE-1:0] axis_tkeep;
  logic             axis_tuser;

  modport master (input axis_tready,
                  output axis_tvalid, axis_tdata, axis_tlast, axis_tkeep, axis_tuser);
  modport slave  (input aclk, axis_tvalid, axis_tdata, axis_tlast, axis_tkeep, axis_tuser,
                  output axis_tready);
endinterface

// File: rtl/pkt_gap_timer.sv
// Loadable down-counter; done is high during the cycle the count sits at 1.
module pkt_gap_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst)               cnt_q <= '0;
    else if (load)         cnt_q <= value;
    else if (cnt_q != '0)  cnt_q <= cnt_q - W'(1);
  end

  assign done = (cnt_q == W'(1));
endmodule

// File: rtl/stream_pkt_gen.sv
// Framed AXI-Stream test packet source with incrementing, seq-seeded payload.
// Define STREAM_PKT_GEN_CSUM_EN to append an XOR checksum beat to each packet.
module stream_pkt_gen
  import stream_pkt_gen_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int LSIZE = 10,
  parameter int GSIZE = 8
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [LSIZE-1:0]     pkt_len,
  input  logic [GSIZE-1:0]     gap,
  output logic                 busy,
  output logic [PKT_CNT_W-1:0] pkt_cnt,
  axi_stream_inf.master        axis_out
);
  localparam int BW = LSIZE + 1;

  pkt_state_e           state_q, state_d;
  logic [BW-1:0]        len_q, len_d, beat_q, beat_d, last_idx;
  logic [DSIZE-1:0]     seed_q, seed_d, tdata_q, tdata_d;
  logic [PKT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, busy_d;
  logic                 start, hs, load_gap, gap_done;
`ifdef STREAM_PKT_GEN_CSUM_EN
  logic [DSIZE-1:0]     csum_q, csum_d;
`endif

  pkt_gap_timer #(.W(GSIZE)) u_gap (
    .clock (clock),
    .rst   (rst),
    .load  (load_gap),
    .value (gap),
    .done  (gap_done)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    beat_d   = beat_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    start    = 1'b0;
    load_gap = 1'b0;
    hs       = tvalid_q & axis_out.axis_tready;
`ifdef STREAM_PKT_GEN_CSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: start = enable;
      SEND: if (hs) begin
        if (tlast_q) begin
          cnt_d    = cnt_q + PKT_CNT_W'(1);
          load_gap = 1'b1;
          if (gap != '0)  state_d = GAP;
          else if (enable) start = 1'b1;
          else             state_d = IDLE;
        end else begin
          beat_d = beat_q + BW'(1);
`ifdef STREAM_PKT_GEN_CSUM_EN
          if (beat_q < len_q) csum_d = csum_q ^ tdata_q;
`endif
        end
      end
      GAP: if (gap_done) begin
        if (enable) start = 1'b1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Seed comes from the post-increment count so back-to-back packets advance.
    if (start) begin
      state_d = SEND;
      len_d   = {pkt_len == '0, pkt_len};
      beat_d  = '0;
      seed_d  = DSIZE'(cnt_d);
`ifdef STREAM_PKT_GEN_CSUM_EN
      csum_d  = '0;
`endif
    end

`ifdef STREAM_PKT_GEN_CSUM_EN
    last_idx = len_d;
`else
    last_idx = len_d - BW'(1);
`endif
    tvalid_d = (state_d == SEND);
    busy_d   = (state_d != IDLE);
    tlast_d  = tvalid_d && (beat_d == last_idx);
    tdata_d  = tdata_q;
    if (tvalid_d) begin
      tdata_d = seed_d + DSIZE'(beat_d);
`ifdef STREAM_PKT_GEN_CSUM_EN
      if (beat_d == len_d) tdata_d = csum_d;
`endif
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      beat_q   <= '0;
      seed_q   <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      busy_q   <= busy_d;
    end
  end

`ifdef STREAM_PKT_GEN_CSUM_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  assign busy                 = busy_q;
  assign pkt_cnt              = cnt_q;
  assign axis_out.axis_tvalid = tvalid_q;
  assign axis_out.axis_tdata  = tdata_q;
  assign axis_out.axis_tlast  = tlast_q;
  assign axis_out.axis_tkeep  = '1;
  assign axis_out.axis_tuser  = 1'b0;
endmodule

// File: tb/tb_stream_pkt_gen.sv
// Scoreboard bench for stream_pkt_gen: stimulus pushes expected beats, monitor pops on handshake.
module tb_stream_pkt_gen;
  localparam int DSIZE = 8;
  localparam int LSIZE = 10;
  localparam int GSIZE = 8;
`ifdef STREAM_PKT_GEN_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct packed {logic [7:0] data; logic last;} beat_t;

  logic             clk = 1'b0;
  logic             rst, enable;
  logic [LSIZE-1:0] pkt_len;
  logic [GSIZE-1:0] gap;
  logic             busy;
  logic [15:0]      pkt_cnt;
  logic             tready_r = 1'b1;
  bit               bp_en = 1'b0;

  beat_t exp_q[$];
  beat_t e_m;
  int    vectors = 0, miscompares = 0, popped = 0;
  logic  prev_stall = 1'b0;
  logic [8:0] prev_beat;

  axi_stream_inf #(.DSIZE(DSIZE)) axis (.aclk(clk));
  assign axis.axis_tready = tready_r;

  stream_pkt_gen #(.DSIZE(DSIZE), .LSIZE(LSIZE), .GSIZE(GSIZE)) dut (
    .clock    (clk),
    .rst      (rst),
    .enable   (enable),
    .pkt_len  (pkt_len),
    .gap      (gap),
    .busy     (busy),
    .pkt_cnt  (pkt_cnt),
    .axis_out (axis.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 tready_r = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int seed, input int len);
    logic [7:0] d, x;
    x = 8'h00;
    for (int i = 0; i < len; i++) begin
      d = 8'(seed + i);
      x ^= d;
      exp_q.push_back('{data: d, last: (!CSUM && i == len - 1)});
    end
    if (CSUM) exp_q.push_back('{data: x, last: 1'b1});
  endtask

  // Monitor: every handshake pops one expected beat; stalls must hold data/last.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {axis.axis_tvalid, axis.axis_tdata, axis.axis_tlast}, {1'b1, prev_beat});
      if (axis.axis_tvalid && axis.axis_tready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got %0h/%0b expected none", axis.axis_tdata, axis.axis_tlast);
        end else begin
          e_m = exp_q.pop_front();
          check("beat", {axis.axis_tdata, axis.axis_tlast}, {e_m.data, e_m.last});
        end
        popped++;
      end
      prev_stall = axis.axis_tvalid && !axis.axis_tready;
      prev_beat  = {axis.axis_tdata, axis.axis_tlast};
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    popped = 0;
    #1 rst = 1'b0;
  endtask

  task automatic drain(input int max, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_tlast(input int max, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(axis.axis_tvalid && axis.axis_tready && axis.axis_tlast) && n < max);
    check(name, n < max, 1);
  endtask

  task automatic run_b2b(input string tag);
    int pk, total, n, drops;
    do_reset();
    pkt_len = 3;
    gap = 0;
    pk = CSUM ? 4 : 3;
    total = 3 * pk;
    push_pkt(0, 3); push_pkt(1, 3); push_pkt(2, 3);
    @(posedge clk); #1 enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axis.axis_tvalid && n < 10);
    drops = 0;
    n = 0;
    while (popped < total && n < 2000) begin
      if (!axis.axis_tvalid) drops++;
      if (popped >= 2 * pk + 1) enable = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_no_bubble"}, drops, 0);
    drain(10, {tag, "_drain"});
    @(posedge clk); #1;
    check({tag, "_pkt_cnt"}, pkt_cnt, 3);
    check({tag, "_idle"}, {axis.axis_tvalid, busy}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; pkt_len = '0; gap = '0;
    #1;
    check("rst_tvalid", axis.axis_tvalid, 0);
    check("rst_tlast", axis.axis_tlast, 0);
    check("rst_tdata", axis.axis_tdata, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    do_reset();

    // Basic packet with enable pulsed one cycle
    pkt_len = 4; gap = 2;
    push_pkt(0, 4);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    check("latency_tvalid", {axis.axis_tvalid, busy, axis.axis_tdata}, {2'b11, 8'h00});
    wait_tlast(50, "basic_tlast_seen");
    @(negedge clk); check("basic_gap1", {axis.axis_tvalid, busy}, 2'b01);
    @(negedge clk); check("basic_gap2", {axis.axis_tvalid, busy}, 2'b01);
    @(negedge clk); check("basic_done", {axis.axis_tvalid, busy}, 2'b00);
    check("basic_pkt_cnt", pkt_cnt, 1);
    check("basic_drained", exp_q.size(), 0);

    // Gap length with enable held high
    do_reset();
    pkt_len = 2; gap = 3;
    push_pkt(0, 2); push_pkt(1, 2);
    @(posedge clk); #1 enable = 1'b1;
    wait_tlast(50, "gap_tlast_seen");
    n = 0;
    @(negedge clk);
    while (!axis.axis_tvalid && n < 20) begin n++; @(negedge clk); end
    check("gap_idle_cycles", n, 3);
    enable = 1'b0;
    drain(50, "gap_drain");
    repeat (6) @(posedge clk); #1;
    check("gap_pkt_cnt", pkt_cnt, 2);
    check("gap_busy_done", busy, 0);

    run_b2b("b2b");
    bp_en = 1'b1;
    run_b2b("bp");
    bp_en = 1'b0;

    // Maximum-length packet (pkt_len = 0)
    do_reset();
    pkt_len = 0; gap = 0;
    push_pkt(0, 1024);
    @(posedge clk); #1 enable = 1'b1;
    @(posedge clk); #1 enable = 1'b0;
    drain(1200, "max_drain");
    @(posedge clk); #1;
    check("max_pkt_cnt", pkt_cnt, 1);
    check("max_idle", axis.axis_tvalid, 0);

    // Reset asserted mid-packet
    do_reset();
    pkt_len = 5; gap = 0;
    push_pkt(0, 5);
    @(posedge clk); #1 enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(axis.axis_tvalid && axis.axis_tdata == 8'h02) && n < 20);
    check("midrst_reach_beat2", n < 20, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_tvalid", axis.axis_tvalid, 0);
    check("midrst_pkt_cnt", pkt_cnt, 0);
    exp_q.delete();
    push_pkt(0, 5);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 enable = 1'b0;
    check("midrst_restart", {axis.axis_tvalid, axis.axis_tdata}, {1'b1, 8'h00});
    drain(50, "midrst_drain");
    @(posedge clk); #1;
    check("midrst_pkt_cnt_after", pkt_cnt, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
